// File: rtl/vm_pkg.sv
// Shared vending-machine datapath definitions: default widths, FSM state
// encoding and the largest legal BCD digit.
package vm_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_to_bin_conv_if.sv
// Start/done handshake and data bus of the BCD-to-binary converter.
// The master issues requests; the slave is the converter.
interface bcd_to_bin_conv_if
  import vm_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd_to_bin_conv_sub_3.sv
// Reverse double-dabble correction cell: subtracts 3 from a BCD digit that
// reads 8 or more after a right shift. Mirror of the add-3 cell.
module sub_3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  // Digits >= 8 cannot underflow when reduced by 3.
  assign out_o = (in_i >= 4'd8) ? (in_i - 4'd3) : in_i;

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Iterative packed-BCD to binary converter (reverse double-dabble).
// One shift/correct iteration per clock; BIN_W iterations per conversion.
module bcd_to_bin_conv
  import vm_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF,
  localparam int CNT_W = $clog2(BIN_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_to_bin_conv_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BIN_W-1:0]   bin_shift;
  logic               in_valid;

  // Right shift of the combined {bcd_sr, bin_sr} register, zero into the MSB.
  assign bcd_shift = {1'b0, bcd_sr_q[BCD_W-1:1]};
  assign bin_shift = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};

  // One correction cell per digit of the shifted BCD field.
  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    sub_3 u_sub_3 (
      .in_i  (bcd_shift[4*g +: 4]),
      .out_o (bcd_corr[4*g +: 4])
    );
  end

  // Flag a request whose operand holds any digit above 9.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    in_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) in_valid = 1'b0;
    end
  end

  // Next-state and datapath control for the IDLE/CONV sequencer.
  always_comb begin
    state_d   = state_q;
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (in_valid) begin
            bcd_sr_d = bus.bcd_in;
            bin_sr_d = '0;
            cnt_d    = '0;
            state_d  = CONV;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      CONV: begin
        bcd_sr_d = bcd_corr;
        bin_sr_d = bin_shift;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_out_d = bin_shift;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = (state_q == CONV);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Directed bench for bcd_to_bin_conv: reset, known values, invalid digits,
// ignored/back-to-back starts, mid-conversion reset and a full 000..999 sweep.
module tb_bcd_to_bin_conv;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_bin_conv_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_to_bin_conv #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge: issues start with the operand, then watches each
  // following negedge until done. lat = clock edges from the start edge to done.
  task automatic run_conv(input logic [11:0] bcd, output int lat, output int busy_cnt,
                          output logic got_done, output logic got_err);
    lat = 0; busy_cnt = 0; got_done = 1'b0; got_err = 1'b0;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start  = 1'b0;
        bus.bcd_in = 12'hFFF;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        got_done = 1'b1;
        got_err = bus.err;
        break;
      end
    end
  endtask

  int   lat, bcnt, dones;
  logic gd, ge;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_bin", bus.bin_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero operand, latency and busy width
    run_conv(12'h000, lat, bcnt, gd, ge);
    check("t1_done", gd, 1);
    check("t1_lat", lat, 10);
    check("t1_busy_cycles", bcnt, 10);
    check("t1_err", ge, 0);
    check("t1_bin", bus.bin_out, 0);

    // 2: known values
    run_conv(12'h255, lat, bcnt, gd, ge);
    check("t2a_lat", lat, 10);
    check("t2a_bin", bus.bin_out, 255);
    run_conv(12'h999, lat, bcnt, gd, ge);
    check("t2b_lat", lat, 10);
    check("t2b_bin", bus.bin_out, 999);

    // 3: invalid digit rejected the cycle after start
    @(negedge clk);
    bus.start = 1'b1; bus.bcd_in = 12'h1A3;
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_done", bus.done, 1);
    check("t3_err", bus.err, 1);
    check("t3_busy", bus.busy, 0);
    check("t3_bin", bus.bin_out, 999);
    @(negedge clk);
    check("t3_done_pulse", bus.done, 0);
    check("t3_err_pulse", bus.err, 0);
    check("t3_busy_after", bus.busy, 0);

    // 4: start while busy is ignored; start in the done cycle is accepted
    bus.start = 1'b1; bus.bcd_in = 12'h125;
    @(posedge clk);
    gd = 1'b0; lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      bus.bcd_in = (k == 3) ? 12'h480 : 12'h000;
      if (bus.done) begin gd = 1'b1; lat = k; break; end
    end
    check("t4a_done", gd, 1);
    check("t4a_lat", lat, 10);
    check("t4a_bin", bus.bin_out, 125);
    run_conv(12'h480, lat, bcnt, gd, ge);
    check("t4b_lat", lat, 10);
    check("t4b_bin", bus.bin_out, 480);

    // 5: reset mid-conversion
    @(negedge clk);
    bus.start = 1'b1; bus.bcd_in = 12'h750;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_err", bus.err, 0);
    check("t5_bin", bus.bin_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("t5_no_done", dones, 0);
    run_conv(12'h750, lat, bcnt, gd, ge);
    check("t5_lat", lat, 10);
    check("t5_bin", bus.bin_out, 750);

    // 6: full sweep, back-to-back
    dones = 0;
    for (int v = 0; v < 1000; v++) begin
      run_conv(to_bcd(v), lat, bcnt, gd, ge);
      if (gd) dones++;
      check($sformatf("sweep_bin_%0d", v), bus.bin_out, v);
    end
    check("sweep_dones", dones, 1000);
    @(negedge clk);
    check("sweep_done_low", bus.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_conv.md
Name: bcd_to_bin_conv

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- It is the inverse of the shift/add-3 binary-to-BCD path already in the vending-machine datapath.
- It converts keypad-entered prices and coin totals held as packed BCD into binary for the credit/price comparators and change arithmetic.
- One iteration per clock, with a start/done handshake.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1. Also equals the iteration count.
- CNT_W, $clog2(BIN_W), iteration counter width (derived).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bcd_in. Sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse; conversion (or rejection) complete.
- err  output  1  one-cycle pulse coincident with done; bcd_in held a digit > 9.
- bin_out  output  BIN_W  registered binary result; holds until the next successful conversion.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, err=0, bin_out=0. Shift register and counter are cleared.
- Reset mid-conversion aborts the conversion immediately. No done is produced.
- Working register: {bcd_sr[4*DIGITS-1:0], bin_sr[BIN_W-1:0]}.
- FSM states: IDLE, CONV.
- IDLE with start=1 and all digits <= 9:
  - load bcd_sr=bcd_in, bin_sr=0, cnt=0;
  - busy=1 from the next cycle; go to CONV.
- IDLE with start=1 and any digit > 9:
  - stay in IDLE; done=1 and err=1 for one cycle, in the cycle after start;
  - bin_out is unchanged.
- CONV, each cycle:
  - shift {bcd_sr, bin_sr} right by 1, with 0 into the MSB;
  - each 4-bit digit of the shifted bcd_sr passes through a sub-3 correction (digit >= 8 -> digit - 3, else unchanged);
  - cnt++.
- CONV exit, on the iteration where cnt == BIN_W-1:
  - bin_out <= the final shifted bin_sr;
  - done=1 for one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge E0; done and bin_out are valid after edge E_BIN_W. That is 10 cycles at the defaults.
- done and err are single-cycle pulses, registered, with no combinational path from inputs.
- start while busy=1 is ignored; it is not queued.
- Back-to-back: the FSM is already in IDLE during the done cycle, so a start in that cycle is accepted.
- bcd_in is sampled only at the load edge; later changes to it have no effect.
- All arithmetic is unsigned. The sub-3 correction never underflows, because it applies only to digits >= 8.

Decomposition:
- Shared package (vm_pkg):
  - DIGITS and BIN_W defaults;
  - state enum (IDLE=1'b0, CONV=1'b1);
  - BCD_MAX_DIGIT=4'd9 constant.
- Sub-module sub_3: a 4-bit combinational correction cell, the mirror of the existing add-3 cell.
  - Output = in - 3 if in >= 8, else in.
  - Instantiated DIGITS times via generate.

Test Plan:
1. bcd_in=12'h000, start pulse -> after 10 cycles done=1, err=0, bin_out=10'd0; busy high for exactly 10 cycles.
2. bcd_in=12'h255 -> done 10 cycles after start; bin_out=10'd255 (0x0FF). Then bcd_in=12'h999 -> bin_out=10'd999 (0x3E7).
3. bcd_in=12'h1A3 (invalid) -> next cycle done=1 and err=1, busy never high, bin_out keeps its prior value (999).
4. start with 12'h125, re-assert start with 12'h480 at cycle 4 -> second start ignored; bin_out=125. Then start with 12'h480 in the done cycle -> accepted; 10 cycles later bin_out=480.
5. Start a conversion of 12'h750, drive rst_n=0 at cycle 5 -> busy, done, err and bin_out go 0 asynchronously. No done after release. A fresh start of 12'h750 yields 750.
6. Sweep all 1000 valid inputs 000..999 back-to-back -> each bin_out equals the decimal value, with exactly one done per start.
